// File: rtl/otter_mem_arbiter.sv
// otter_mem_arbiter: shares one single-ported OTTER memory between the
// instruction-fetch port (if_*) and the load/store port (dm_*).
//
// Ports:
//   CLK, RST_N             clock, asynchronous active-low reset
//   if_req/if_addr         fetch request (word read), held until if_done
//   if_done/rdata/err      one-cycle completion pulse, data, timeout flag
//   if_stall               combinational: if_req && !if_done
//   dm_req/we/addr/wdata/size/sign   load/store request, held until dm_done
//   dm_done/rdata/err/stall          same rules as the fetch port
//   mem_req/we/addr/wdata/size/sign  registered memory command
//   mem_ack/mem_rdata      memory completion and read data
//
// Data accesses win collisions unless fetch has been passed over STARVE_MAX
// times in a row. A GRANT lasting TIMEOUT cycles without mem_ack is aborted
// and reported with err set.

package otter_mem_arbiter_pkg;
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [1:0]      size;
        logic            sign;
    } mem_cmd_t;
endpackage

module otter_mem_arbiter
    import otter_mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic            CLK,
    input  logic            RST_N,

    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_done,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_err,
    output logic            if_stall,

    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [XLEN-1:0] dm_addr,
    input  logic [XLEN-1:0] dm_wdata,
    input  logic [1:0]      dm_size,
    input  logic            dm_sign,
    output logic            dm_done,
    output logic [XLEN-1:0] dm_rdata,
    output logic            dm_err,
    output logic            dm_stall,

    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [1:0]      mem_size,
    output logic            mem_sign,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int unsigned      CNT_W      = 4;
    localparam int unsigned      TMR_W      = 8;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              owner_dm_q, owner_dm_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    mem_cmd_t          cmd_q, cmd_d;
    logic              mem_req_q, mem_req_d;
    logic              if_done_q, if_done_d;
    logic [XLEN-1:0]   if_rdata_q, if_rdata_d;
    logic              if_err_q, if_err_d;
    logic              dm_done_q, dm_done_d;
    logic [XLEN-1:0]   dm_rdata_q, dm_rdata_d;
    logic              dm_err_q, dm_err_d;

    logic              grant_dm_c;
    logic              finish_c;
    logic [XLEN-1:0]   rsp_data_c;

    // State and output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            owner_dm_q <= 1'b0;
            starve_q   <= '0;
            timer_q    <= '0;
            cmd_q      <= '0;
            mem_req_q  <= 1'b0;
            if_done_q  <= 1'b0;
            if_rdata_q <= '0;
            if_err_q   <= 1'b0;
            dm_done_q  <= 1'b0;
            dm_rdata_q <= '0;
            dm_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_dm_q <= owner_dm_d;
            starve_q   <= starve_d;
            timer_q    <= timer_d;
            cmd_q      <= cmd_d;
            mem_req_q  <= mem_req_d;
            if_done_q  <= if_done_d;
            if_rdata_q <= if_rdata_d;
            if_err_q   <= if_err_d;
            dm_done_q  <= dm_done_d;
            dm_rdata_q <= dm_rdata_d;
            dm_err_q   <= dm_err_d;
        end
    end

    // Next-state, arbitration and response capture
    always_comb begin
        state_d    = state_q;
        owner_dm_d = owner_dm_q;
        starve_d   = starve_q;
        timer_d    = timer_q;
        cmd_d      = cmd_q;
        mem_req_d  = 1'b0;
        if_done_d  = 1'b0;
        if_rdata_d = if_rdata_q;
        if_err_d   = if_err_q;
        dm_done_d  = 1'b0;
        dm_rdata_d = dm_rdata_q;
        dm_err_d   = dm_err_q;
        grant_dm_c = 1'b0;
        finish_c   = 1'b0;
        rsp_data_c = '0;

        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (if_req || dm_req) begin
                    // Fetch only overrides a colliding data request once starved.
                    grant_dm_c = dm_req && (!if_req || (starve_q != STARVE_LIM));
                    owner_dm_d = grant_dm_c;
                    state_d    = ST_GRANT;
                    mem_req_d  = 1'b1;
                    if (grant_dm_c) begin
                        cmd_d.we    = dm_we;
                        cmd_d.addr  = dm_addr;
                        cmd_d.wdata = dm_wdata;
                        cmd_d.size  = dm_size;
                        cmd_d.sign  = dm_sign;
                        if (if_req) begin
                            starve_d = (starve_q == STARVE_LIM) ? starve_q
                                                                : starve_q + CNT_W'(1);
                        end else begin
                            starve_d = '0;
                        end
                    end else begin
                        cmd_d.we    = 1'b0;
                        cmd_d.addr  = if_addr;
                        cmd_d.wdata = '0;
                        cmd_d.size  = 2'd2;
                        cmd_d.sign  = 1'b0;
                        starve_d    = '0;
                    end
                end
            end

            ST_GRANT: begin
                timer_d  = timer_q + TMR_W'(1);
                // An ack arriving on the timeout cycle still completes normally.
                finish_c = mem_ack || (timer_q == TMR_LAST);
                if (mem_ack && !cmd_q.we) begin
                    rsp_data_c = mem_rdata;
                end
                if (finish_c) begin
                    state_d = ST_RESP;
                    if (owner_dm_q) begin
                        dm_done_d  = 1'b1;
                        dm_rdata_d = rsp_data_c;
                        dm_err_d   = !mem_ack;
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = rsp_data_c;
                        if_err_d   = !mem_ack;
                    end
                end else begin
                    mem_req_d = 1'b1;
                end
            end

            ST_RESP: begin
                timer_d = '0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = cmd_q.we;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;
    assign mem_size  = cmd_q.size;
    assign mem_sign  = cmd_q.sign;

    assign if_done   = if_done_q;
    assign if_rdata  = if_rdata_q;
    assign if_err    = if_err_q;
    assign dm_done   = dm_done_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_err    = dm_err_q;

    // Stalls are the only combinational outputs.
    assign if_stall  = if_req && !if_done_q;
    assign dm_stall  = dm_req && !dm_done_q;

endmodule

// File: doc/otter_mem_arbiter.md
# otter_mem_arbiter

Sequential arbiter that shares one single-ported OTTER memory between the instruction-fetch port and the load/store port of the 5-stage pipeline. It registers one request at a time toward memory and waits for the memory's acknowledge. It returns read data with a one-cycle done pulse and drives per-port stall outputs for the hazard logic. Data accesses normally have priority; a starvation counter guarantees fetch progress, and a timeout guarantees forward progress if memory never acknowledges.

## Interface
- STARVE_MAX, 4: consecutive data grants allowed while fetch waits (1..15).
- TIMEOUT, 255: GRANT cycles without mem_ack before abort (1..255).
- CLK  in  1  single clock; all state on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr stable until if_done.
- if_addr  in  32  fetch byte address; word read, size 2, unsigned.
- if_done  out  1  one-cycle completion pulse.
- if_rdata  out  32  fetch data, valid when if_done.
- if_err  out  1  with if_done: access timed out.
- if_stall  out  1  if_req && !if_done.
- dm_req  in  1  data request; held with all dm_* fields stable until dm_done.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  store data.
- dm_size  in  2  0 byte, 1 half, 2 word.
- dm_sign  in  1  load sign-extend (0 = unsigned).
- dm_done, dm_rdata, dm_err, dm_stall  out  1/32/1/1  same rules as fetch port.
- mem_req  out  1  registered; high for the whole GRANT state.
- mem_we, mem_addr, mem_wdata, mem_size, mem_sign  out  1/32/32/2/1  registered command, stable while mem_req.
- mem_ack  in  1  memory completes the access this cycle.
- mem_rdata  in  32  valid when mem_ack and !mem_we.

## Operation
- States: IDLE, GRANT, RESP. Reset: IDLE, all outputs 0, starve_cnt 0, timer 0, owner = fetch.
- IDLE: if no req, stay. Otherwise pick winner, latch command into mem_*, latch owner, go GRANT.
  - Only one req: that one wins.
  - Both req: dm wins, unless starve_cnt == STARVE_MAX, then fetch wins.
- Fetch grant: mem_we = 0, mem_size = 2, mem_sign = 0, mem_wdata = 0.
- starve_cnt update at each grant:
  - dm granted while if_req high: increment, saturating at STARVE_MAX.
  - Any fetch grant: clear to 0.
  - dm granted with if_req low: clear to 0.
- GRANT: mem_req = 1; timer increments each cycle.
  - mem_ack: capture mem_rdata (stores capture 0), err = 0, go RESP.
  - Else if timer == TIMEOUT - 1: drop mem_req, rdata = 0, err = 1, go RESP.
  - mem_ack in the same cycle as the timeout: ack wins.
- RESP: owner's done = 1 with rdata/err; the other port's done = 0. mem_req = 0, timer = 0, go IDLE.
  - Requests are ignored during RESP; the requester drops or renews req in this cycle.
  - A req still high in the following IDLE cycle is a new transaction.
- rdata/err hold their value until the next RESP. done is a pulse only.
- mem_ack outside GRANT is ignored.
- Reset mid-operation: mem_req drops asynchronously; the transaction is abandoned with no done pulse.

## Timing
- Request first high at cycle 0 while IDLE:
  - cycle 1: GRANT, mem_req high.
  - mem_ack at cycle k ≥ 1.
  - cycle k+1: done pulse.
  - cycle k+2: IDLE.
- Minimum latency req→done is 2 cycles. Back-to-back issue interval from one port is 3 cycles.
- Timeout: done at cycle TIMEOUT + 1 after grant decision.
- No combinational path from any input to mem_* or done. Only the stall outputs are combinational.

## Test plan
- Single fetch: if_req at cycle 0, addr 0x100, mem_ack at cycle 1, mem_rdata 0xDEADBEEF -> mem_req cycles 1 only, if_done at cycle 2, if_rdata 0xDEADBEEF, if_err 0, mem_size 2.
- Collision: if_req and dm_req (load, addr 0x2000, size 1, sign 1) both rise at cycle 0, ack immediate -> dm served first (dm_done at 2); fetch granted at cycle 4, if_done at 5; mem_size/mem_sign match each owner.
- Starvation with STARVE_MAX = 4: dm_req and if_req held continuously, ack immediate -> grant order dm,dm,dm,dm,if,dm,...; fetch granted on the 5th grant.
- Store: dm_we 1, addr 0x3004, wdata 0x12345678, size 0, ack delayed 3 cycles -> mem_* stable for 3 GRANT cycles, dm_done one cycle after ack, dm_rdata 0, dm_err 0.
- Timeout with TIMEOUT = 8: dm_req, mem_ack never -> mem_req high exactly 8 cycles, dm_done with dm_err 1, dm_rdata 0. A late mem_ack in RESP/IDLE is ignored.
- Reset during GRANT: RST_N low mid-access -> mem_req 0 immediately, no done pulse, starve_cnt 0. After release with if_req high, a fresh grant occurs 1 cycle later.
